// File: rtl/ti_share_masker.sv
// Splits a plain nibble into NSHARES Boolean shares using a 32-bit Galois LFSR.
// Optional macro TI_REFRESH_EN: re-randomise the held shares on every stall cycle.
module ti_share_masker #(
  parameter int DATA_W  = 4,
  parameter int NSHARES = 4,
  parameter int LFSR_W  = 32
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        seed_load,
  input  logic [31:0]                 seed,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [DATA_W-1:0]           in_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [NSHARES*DATA_W-1:0]   out_shares
);

  localparam int R     = (NSHARES - 1) * DATA_W;
  localparam int OUT_W = NSHARES * DATA_W;
  localparam logic [LFSR_W-1:0] POLY_MASK = 32'h8020_0003;
  localparam logic [LFSR_W-1:0] LFSR_INIT = 32'h0000_0001;

  logic [LFSR_W-1:0] lfsr;
  logic [LFSR_W-1:0] lfsr_adv;
  logic [R-1:0]      rnd;
  logic [OUT_W-1:0]  mask_vec;
  logic [DATA_W-1:0] share0_mask;
  logic              accept;
  logic              transfer;
  logic              refresh;
  logic              advance;

  // rnd[i] is bit0 of the state before the i-th of R successive steps
  always_comb begin
    lfsr_adv = lfsr;
    rnd      = '0;
    for (int i = 0; i < R; i++) begin
      rnd[i]   = lfsr_adv[0];
      lfsr_adv = (lfsr_adv >> 1) ^ (lfsr_adv[0] ? POLY_MASK : '0);
    end
  end

  // Share 0 carries the XOR of all random shares so the vector recombines to zero
  always_comb begin
    mask_vec    = '0;
    share0_mask = '0;
    for (int k = 1; k < NSHARES; k++) begin
      mask_vec[k*DATA_W +: DATA_W] = rnd[(k-1)*DATA_W +: DATA_W];
      share0_mask                  = share0_mask ^ rnd[(k-1)*DATA_W +: DATA_W];
    end
    mask_vec[DATA_W-1:0] = share0_mask;
  end

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign transfer = out_valid && out_ready;

`ifdef TI_REFRESH_EN
  assign refresh = out_valid && !out_ready;
`else
  assign refresh = 1'b0;
`endif

  assign advance = accept || refresh;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr <= LFSR_INIT;
    end else if (seed_load) begin
      lfsr <= (seed == '0) ? LFSR_INIT : seed;
    end else if (advance) begin
      lfsr <= lfsr_adv;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_shares <= '0;
    end else if (accept) begin
      out_valid  <= 1'b1;
      out_shares <= mask_vec ^ {{(OUT_W-DATA_W){1'b0}}, in_data};
    end else begin
      if (transfer) out_valid <= 1'b0;
      if (refresh)  out_shares <= out_shares ^ mask_vec;
    end
  end

endmodule

// File: tb/tb_ti_share_masker.sv
// Directed self-checking bench for ti_share_masker (default 4 shares of 4 bits).
// Expected shares come from a local Galois LFSR model tracked alongside the DUT.
module tb_ti_share_masker;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        seed_load;
  logic [31:0] seed;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_data;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_shares;

  int checks = 0;
  int errors = 0;
  int xfers  = 0;

  logic [31:0] model;
  logic [11:0] rnd;
  logic [31:0] nxt;
  logic [15:0] exp_s;
  logic [15:0] prev_s;

  ti_share_masker dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .seed_load  (seed_load),
    .seed       (seed),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_shares (out_shares)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (rst_n && out_valid && out_ready) xfers++;

  task automatic gen(input logic [31:0] s, output logic [11:0] r, output logic [31:0] n);
    n = s;
    r = '0;
    for (int i = 0; i < 12; i++) begin
      r[i] = n[0];
      n    = (n >> 1) ^ (n[0] ? 32'h8020_0003 : 32'h0);
    end
  endtask

  function automatic logic [15:0] mask_of(input logic [11:0] r);
    return {r[11:8], r[7:4], r[3:0], r[11:8] ^ r[7:4] ^ r[3:0]};
  endfunction

  function automatic logic [3:0] recomb(input logic [15:0] v);
    return v[15:12] ^ v[11:8] ^ v[7:4] ^ v[3:0];
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; seed_load = 1'b0; seed = '0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    model = 32'h1;
    #12;
    checks++;
    if (out_valid !== 1'b0 || out_shares !== 16'h0) begin
      errors++;
      $display("FAIL reset_out: valid=%b shares=%h required valid=0 shares=0000", out_valid, out_shares);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: got %b required 1", in_ready);
    end
  endtask

  task automatic test_seed_zero;
    seed_load = 1'b1; seed = 32'h0;
    tick();
    seed_load = 1'b0;
    model = 32'h1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL seed_zero_hs: valid=%b ready=%b required 0/1", out_valid, in_ready);
    end
    in_valid = 1'b1; in_data = 4'h7; out_ready = 1'b1;
    gen(model, rnd, nxt); exp_s = mask_of(rnd) ^ 16'h0007; model = nxt;
    tick();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_shares !== exp_s) begin
      errors++;
      $display("FAIL seed_zero_shares: valid=%b shares=%h required 1 %h", out_valid, out_shares, exp_s);
    end
    tick();
  endtask

  task automatic test_single;
    seed_load = 1'b1; seed = 32'hACE1_2345;
    tick();
    seed_load = 1'b0;
    model = 32'hACE1_2345;
    in_valid = 1'b1; in_data = 4'hA; out_ready = 1'b1;
    gen(model, rnd, nxt); exp_s = mask_of(rnd) ^ 16'h000A; model = nxt;
    tick();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL single_valid: got %b required 1", out_valid);
    end
    checks++;
    if (recomb(out_shares) !== 4'hA) begin
      errors++;
      $display("FAIL single_recomb: got %h required a", recomb(out_shares));
    end
    checks++;
    if (out_shares !== exp_s) begin
      errors++;
      $display("FAIL single_shares: got %h required %h", out_shares, exp_s);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_drain: valid=%b required 0", out_valid);
    end
  endtask

  task automatic test_back_to_back;
    int x0;
    x0 = xfers;
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b1; in_data = 4'(i);
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
        errors++;
        $display("FAIL b2b_ready[%0d]: got %b required 1", i, in_ready);
      end
      gen(model, rnd, nxt); exp_s = mask_of(rnd) ^ {12'h0, 4'(i)}; model = nxt;
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_shares !== exp_s) begin
        errors++;
        $display("FAIL b2b_shares[%0d]: valid=%b shares=%h required 1 %h", i, out_valid, out_shares, exp_s);
      end
    end
    in_valid = 1'b0;
    tick();
    checks++;
    if (xfers - x0 !== 16 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_count: transfers=%0d valid=%b required 16 0", xfers - x0, out_valid);
    end
  endtask

  task automatic test_stall;
    int x0;
    x0 = xfers;
    in_valid = 1'b1; in_data = 4'h5; out_ready = 1'b0;
    gen(model, rnd, nxt); exp_s = mask_of(rnd) ^ 16'h0005; model = nxt;
    tick();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_shares !== exp_s) begin
      errors++;
      $display("FAIL stall_load: valid=%b shares=%h required 1 %h", out_valid, out_shares, exp_s);
    end
    for (int c = 0; c < 5; c++) begin
      prev_s = exp_s;
`ifdef TI_REFRESH_EN
      gen(model, rnd, nxt); exp_s = prev_s ^ mask_of(rnd); model = nxt;
`endif
      tick();
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
        errors++;
        $display("FAIL stall_hs[%0d]: ready=%b valid=%b required 0 1", c, in_ready, out_valid);
      end
      checks++;
      if (out_shares !== exp_s || recomb(out_shares) !== 4'h5) begin
        errors++;
        $display("FAIL stall_shares[%0d]: got %h required %h (recombines to 5)", c, out_shares, exp_s);
      end
    end
    out_ready = 1'b1;
    tick();
    tick();
    checks++;
    if (xfers - x0 !== 1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL stall_xfer: transfers=%0d valid=%b required 1 0", xfers - x0, out_valid);
    end
  endtask

  task automatic test_reset_mid_stall;
    int x0;
    in_valid = 1'b1; in_data = 4'hC; out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    x0 = xfers;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_shares !== 16'h0) begin
      errors++;
      $display("FAIL rst_async: valid=%b shares=%h required 0 0000", out_valid, out_shares);
    end
    model = 32'h1;
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    tick(); tick(); tick();
    checks++;
    if (xfers !== x0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_no_xfer: transfers=%0d valid=%b required %0d 0", xfers, out_valid, x0);
    end
  endtask

  task automatic test_seed_with_accept;
    out_ready = 1'b1;
    seed_load = 1'b1; seed = 32'h1357_9BDF;
    in_valid = 1'b1; in_data = 4'h3;
    gen(model, rnd, nxt); exp_s = mask_of(rnd) ^ 16'h0003;
    model = 32'h1357_9BDF;
    tick();
    seed_load = 1'b0;
    checks++;
    if (out_shares !== exp_s) begin
      errors++;
      $display("FAIL seed_acc_old: got %h required %h", out_shares, exp_s);
    end
    in_data = 4'h9;
    gen(model, rnd, nxt); exp_s = mask_of(rnd) ^ 16'h0009; model = nxt;
    tick();
    in_valid = 1'b0;
    checks++;
    if (out_shares !== exp_s || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL seed_acc_new: shares=%h valid=%b required %h 1", out_shares, out_valid, exp_s);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_seed_zero();
    test_single();
    test_back_to_back();
    test_stall();
    test_reset_mid_stall();
    test_seed_with_accept();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
